sc_spi_tgt: RTL and testbench
=============================

# sc_spi_tgt

SPI target (slave) protocol engine: the far end of the team's SPI master engine. Oversamples the external SCSB/SSCLK/SMOSI lines on the local SPICLK, shifts received bits into words, and drives SMISO from a one-entry transmit holding register. It supports all four CPOL/CPHA modes and word widths of 1–32 bits, MSB first. It sits between the SPI pins and a register/FIFO front end that consumes RXDATA/RXVALID and supplies TXDATA through a valid/ready handshake.

## Interface
- No parameters. Word width and mode are set at run time through ports.
- SPICLK  in  1  block clock. All logic is on the rising edge. It must be at least 8× the SSCLK frequency.
- SYSRST  in  1  reset, asynchronous, active-high.
- CPOL  in  1  SSCLK idle level. Static while SCSB is low.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge. Static while SCSB is low.
- DWIDTH  in  5  word width minus 1 (0 = 1 bit, 31 = 32 bits). Static while SCSB is low.
- TXDATA  in  32  next word to transmit, right-justified.
- TXVALID  in  1  TXDATA valid.
- TXREADY  out  1  holding register empty. A transfer occurs when TXVALID and TXREADY are both high.
- TXUNDER  out  1  one-cycle pulse: a word load found the holding register empty.
- RXDATA  out  32  last received word, right-justified, upper bits zero.
- RXVALID  out  1  one-cycle pulse: RXDATA updated.
- BUSY  out  1  synchronized SCSB is low.
- SCSB, SSCLK, SMOSI  in  1  SPI pins, asynchronous.
- SMISO  out  1  serial data out.
- SMISOOE  out  1  SMISO output enable (equals BUSY).

## Operation
- **Input path.** SCSB, SSCLK and SMOSI each pass through a 2-FF synchronizer plus one history FF.
  - Edge detect runs on the synchronized SSCLK.
  - The leading edge is rising when CPOL=0 and falling when CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge.
- **States.**
  - IDLE → ACTIVE on synchronized SCSB falling. The word loads on entry.
  - ACTIVE → IDLE on synchronized SCSB rising.
  - SSCLK edges in IDLE are ignored.
- **Bit counter bc (5 bits).**
  - Cleared on word load.
  - Incremented on each sample edge.
  - When bc == DWIDTH at a sample edge, the word is complete: bc wraps to 0 in the same cycle.
- **Receive.**
  - Each sample edge: rsr <= {rsr[30:0], SMOSI_sync}.
  - On word completion: RXDATA <= the new rsr value masked to DWIDTH+1 bits, and RXVALID pulses in the same cycle RXDATA changes.
- **Transmit.**
  - A word load moves the holding register to tsr and sets TXREADY=1.
  - If the holding register is empty, tsr <= 0 and TXUNDER pulses.
  - SMISO = tsr[DWIDTH] (registered).
- **Load and shift points.**
  - CPHA=0: load on IDLE→ACTIVE and at the first shift edge after word completion. Every other shift edge shifts tsr left by 1.
  - CPHA=1: load at the first shift edge of each word, so SMISO shows the MSB from that edge. Subsequent shift edges of the word shift tsr.
- **Holding register.**
  - Accepts TXDATA when TXVALID & TXREADY; TXREADY falls the next cycle.
  - Acceptance and load in the same cycle: the load takes the old contents (or underruns if it was empty), and the new word stays in the holding register.
- **SCSB rising mid-word.**
  - The partial word is discarded and bc/tsr/rsr are cleared.
  - The holding register is retained.
  - SMISO = 0.
- **Reset values.**
  - Outputs: RXDATA=0, RXVALID=0, TXREADY=1, TXUNDER=0, BUSY=0, SMISO=0, SMISOOE=0.
  - Internal: holding register empty, state IDLE.
  - Reset is asynchronous, so it aborts any frame immediately.

## Timing
- Pin-to-detect latency is 3 SPICLK cycles (2 sync FFs plus the edge register).
- RXVALID asserts 3 cycles after the last sampled SSCLK edge.
- For CPHA=0, the first MSB appears on SMISO 4 cycles after SCSB falls. The master must allow at least 4 SPICLK cycles of CS setup.
- SMISO changes 4 cycles after a shift edge. This requires an SSCLK half-period of at least 4 SPICLK cycles.
- The TXDATA for word n+1 must be accepted before the load point of word n+1, otherwise TXUNDER fires.

## Configuration
- `SC_SPI_TGT_PARTIAL_EN`
  - **Defined:** when SCSB rises with bc != 0, RXDATA <= the partial rsr, right-justified over bc bits, and RXVALID pulses. TXUNDER is unaffected.
  - **Undefined:** the partial word is silently discarded, as described under Operation.

## Test plan
- **Mode 0, 8-bit word.** DWIDTH=7, holding register loaded with 0xA5, master sends 0x3C → RXDATA=0x3C with one RXVALID pulse; master receives 0xA5; TXREADY=1 after the load.
- **Modes 1, 2 and 3, 32-bit word.** DWIDTH=31, TX=0xDEADBEEF, master sends 0x12345678 → RXDATA=0x12345678; master receives 0xDEADBEEF in each mode.
- **Back-to-back words in one frame.** Two 16-bit words in one SCSB-low window, TX words 0x1111 then 0x2222 supplied in time → two RXVALID pulses; master receives 0x1111 then 0x2222; no TXUNDER.
- **Underrun.** Second word not supplied → TXUNDER pulses once at the second load; master receives 0x0000.
- **Aborted word.** SCSB rises after 5 of 8 bits → no RXVALID without the macro; with the macro, RXVALID fires and RXDATA holds the 5 bits received. The next frame starts clean at bc=0.
- **Reset mid-frame.** SYSRST asserted mid-word → all outputs at reset values on the same edge; a new frame after release transfers correctly.

Source files
------------

// File: rtl/sc_spi_tgt.sv
// SPI target engine: oversampled SCSB/SSCLK/SMOSI, all four CPOL/CPHA modes, 1-32 bit MSB-first words.
// Optional macro SC_SPI_TGT_PARTIAL_EN reports a partial word when SCSB rises mid-word.
module sc_spi_tgt (
    input  logic        SPICLK,
    input  logic        SYSRST,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic [4:0]  DWIDTH,
    input  logic [31:0] TXDATA,
    input  logic        TXVALID,
    output logic        TXREADY,
    output logic        TXUNDER,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic        BUSY,
    input  logic        SCSB,
    input  logic        SSCLK,
    input  logic        SMOSI,
    output logic        SMISO,
    output logic        SMISOOE
);

    function automatic logic [31:0] width_mask(input logic [4:0] dw);
        width_mask = 32'hFFFF_FFFF >> (5'd31 - dw);
    endfunction

`ifdef SC_SPI_TGT_PARTIAL_EN
    function automatic logic [31:0] low_mask(input logic [4:0] n);
        low_mask = ~(32'hFFFF_FFFF << n);
    endfunction
`endif

    logic        scsb_p0, scsb_p1, scsb_p2;
    logic        sclk_p0, sclk_p1, sclk_p2;
    logic        mosi_p0, mosi_p1;

    logic        active, active_n;
    logic        need_load, need_n;
    logic [4:0]  bc, bc_n;
    logic [31:0] rsr, rsr_n;
    logic [31:0] tsr, tsr_n;
    logic [31:0] hold_data;
    logic        hold_full, hold_full_n;
    logic [31:0] rxdata_n;
    logic        rxvalid_n, under_n, load, accept;

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;

    assign cs_fall     = ~scsb_p1 & scsb_p2;
    assign cs_rise     = scsb_p1 & ~scsb_p2;
    assign sclk_rise   = sclk_p1 & ~sclk_p2;
    assign sclk_fall   = ~sclk_p1 & sclk_p2;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign accept      = TXVALID & ~hold_full;

    always_comb begin
        active_n  = active;
        need_n    = need_load;
        bc_n      = bc;
        rsr_n     = rsr;
        tsr_n     = tsr;
        rxdata_n  = RXDATA;
        rxvalid_n = 1'b0;
        under_n   = 1'b0;
        load      = 1'b0;
        if (!active) begin
            if (cs_fall) begin
                active_n = 1'b1;
                bc_n     = 5'd0;
                rsr_n    = 32'd0;
                // CPHA=1 defers the first load to the leading edge
                need_n   = CPHA;
                load     = ~CPHA;
            end
        end else if (cs_rise) begin
            active_n = 1'b0;
            need_n   = 1'b0;
            bc_n     = 5'd0;
            rsr_n    = 32'd0;
            tsr_n    = 32'd0;
`ifdef SC_SPI_TGT_PARTIAL_EN
            if (bc != 5'd0) begin
                rxdata_n  = rsr & low_mask(bc);
                rxvalid_n = 1'b1;
            end
`endif
        end else begin
            if (sample_edge) begin
                rsr_n = {rsr[30:0], mosi_p1};
                if (bc == DWIDTH) begin
                    bc_n      = 5'd0;
                    rxdata_n  = rsr_n & width_mask(DWIDTH);
                    rxvalid_n = 1'b1;
                    need_n    = 1'b1;
                end else begin
                    bc_n = bc + 5'd1;
                end
            end
            if (shift_edge) begin
                if (need_load) begin
                    load   = 1'b1;
                    need_n = 1'b0;
                end else begin
                    tsr_n = {tsr[30:0], 1'b0};
                end
            end
        end
        if (load) begin
            bc_n    = 5'd0;
            tsr_n   = hold_full ? hold_data : 32'd0;
            under_n = ~hold_full;
        end
        // a same-cycle accept only happens when the register was empty, so it always wins
        hold_full_n = accept | (hold_full & ~load);
    end

    // stage p0/p1: synchronizers, p2: edge history
    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            scsb_p0 <= 1'b1;
            scsb_p1 <= 1'b1;
            scsb_p2 <= 1'b1;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            scsb_p0 <= SCSB;
            scsb_p1 <= scsb_p0;
            scsb_p2 <= scsb_p1;
            sclk_p0 <= SSCLK;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= SMOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    // protocol state, shift registers and outputs
    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            active    <= 1'b0;
            need_load <= 1'b0;
            bc        <= 5'd0;
            rsr       <= 32'd0;
            tsr       <= 32'd0;
            hold_data <= 32'd0;
            hold_full <= 1'b0;
            RXDATA    <= 32'd0;
            RXVALID   <= 1'b0;
            TXUNDER   <= 1'b0;
            SMISO     <= 1'b0;
        end else begin
            active    <= active_n;
            need_load <= need_n;
            bc        <= bc_n;
            rsr       <= rsr_n;
            tsr       <= tsr_n;
            hold_full <= hold_full_n;
            if (accept)
                hold_data <= TXDATA;
            RXDATA    <= rxdata_n;
            RXVALID   <= rxvalid_n;
            TXUNDER   <= under_n;
            SMISO     <= active ? tsr[DWIDTH] : 1'b0;
        end
    end

    assign TXREADY = ~hold_full;
    assign BUSY    = active;
    assign SMISOOE = active;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// Directed bench for sc_spi_tgt: bit-banged SPI master plus an RX scoreboard queue.
module tb_sc_spi_tgt;

    localparam int H = 8;

    logic        SPICLK = 1'b0;
    logic        SYSRST = 1'b1;
    logic        CPOL = 1'b0, CPHA = 1'b0;
    logic [4:0]  DWIDTH = 5'd7;
    logic [31:0] TXDATA = 32'd0;
    logic        TXVALID = 1'b0;
    logic        TXREADY, TXUNDER, RXVALID, BUSY, SMISO, SMISOOE;
    logic [31:0] RXDATA;
    logic        SCSB = 1'b1, SSCLK = 1'b0, SMOSI = 1'b0;

    int n_chk = 0, n_pass = 0;
    int rx_cnt = 0, un_cnt = 0;
    logic [31:0] rxq[$];

    sc_spi_tgt dut (
        .SPICLK(SPICLK), .SYSRST(SYSRST), .CPOL(CPOL), .CPHA(CPHA), .DWIDTH(DWIDTH),
        .TXDATA(TXDATA), .TXVALID(TXVALID), .TXREADY(TXREADY), .TXUNDER(TXUNDER),
        .RXDATA(RXDATA), .RXVALID(RXVALID), .BUSY(BUSY),
        .SCSB(SCSB), .SSCLK(SSCLK), .SMOSI(SMOSI), .SMISO(SMISO), .SMISOOE(SMISOOE)
    );

    always #5 SPICLK = ~SPICLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge SPICLK) begin
        if (TXUNDER) un_cnt++;
        if (RXVALID) begin
            rx_cnt++;
            if (rxq.size() == 0) chk("rx_unexpected", rxq.size(), 1);
            else chk("rxdata", RXDATA, rxq.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge SPICLK);
    endtask

    task automatic push_tx(input logic [31:0] d);
        int k;
        @(negedge SPICLK);
        for (k = 0; k < 50 && !TXREADY; k++) @(negedge SPICLK);
        chk("txready_wait", TXREADY, 1);
        TXDATA = d;
        TXVALID = 1'b1;
        @(negedge SPICLK);
        TXVALID = 1'b0;
    endtask

    task automatic hwait(input bit push, input logic [31:0] d);
        if (push) begin
            TXDATA = d;
            TXVALID = 1'b1;
            @(negedge SPICLK);
            TXVALID = 1'b0;
            cyc(H - 1);
        end else begin
            cyc(H);
        end
    endtask

    task automatic frame(input bit cpol, input bit cpha, input int bits, input int nwords,
                         input logic [31:0] m0, input logic [31:0] m1,
                         input bit sup2, input logic [31:0] t1, input int abort_at,
                         output logic [31:0] r0, output logic [31:0] r1);
        logic [31:0] word;
        logic rbit;
        int w, i;
        r0 = 32'd0;
        r1 = 32'd0;
        @(negedge SPICLK);
        CPOL = cpol;
        CPHA = cpha;
        DWIDTH = 5'(bits - 1);
        SSCLK = cpol;
        cyc(4);
        SCSB = 1'b0;
        if (cpha) cyc(H);
        for (int k = 0; k < nwords * bits; k++) begin
            if (abort_at > 0 && k == abort_at) break;
            w = k / bits;
            i = bits - 1 - (k % bits);
            word = (w == 0) ? m0 : m1;
            if (!cpha) begin
                SMOSI = word[i];
                hwait(sup2 && k == 1, t1);
                rbit = SMISO;
                SSCLK = ~cpol;
                cyc(H);
                SSCLK = cpol;
            end else begin
                SSCLK = ~cpol;
                SMOSI = word[i];
                hwait(sup2 && k == 1, t1);
                rbit = SMISO;
                SSCLK = cpol;
                cyc(H);
            end
            if (w == 0) r0 = {r0[30:0], rbit};
            else r1 = {r1[30:0], rbit};
        end
        cyc(H);
        SCSB = 1'b1;
        cyc(10);
    endtask

    initial begin
        logic [31:0] r0, r1;
        int rx0, un0;

        // reset values
        cyc(3);
        chk("rst_rxdata", RXDATA, 0);
        chk("rst_rxvalid", RXVALID, 0);
        chk("rst_txready", TXREADY, 1);
        chk("rst_txunder", TXUNDER, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_smiso", SMISO, 0);
        chk("rst_smisooe", SMISOOE, 0);
        SYSRST = 1'b0;
        cyc(4);

        // mode 0, 8-bit
        push_tx(32'hA5);
        rx0 = rx_cnt;
        rxq.push_back(32'h3C);
        frame(0, 0, 8, 1, 32'h3C, 0, 0, 0, 0, r0, r1);
        chk("m0_miso", r0, 32'hA5);
        chk("m0_txready", TXREADY, 1);
        chk("m0_rxpulses", rx_cnt - rx0, 1);

        // modes 1..3, 32-bit
        push_tx(32'hDEADBEEF);
        rxq.push_back(32'h12345678);
        frame(0, 1, 32, 1, 32'h12345678, 0, 0, 0, 0, r0, r1);
        chk("m1_miso", r0, 32'hDEADBEEF);
        push_tx(32'hDEADBEEF);
        rxq.push_back(32'h12345678);
        frame(1, 0, 32, 1, 32'h12345678, 0, 0, 0, 0, r0, r1);
        chk("m2_miso", r0, 32'hDEADBEEF);
        push_tx(32'hDEADBEEF);
        rxq.push_back(32'h12345678);
        frame(1, 1, 32, 1, 32'h12345678, 0, 0, 0, 0, r0, r1);
        chk("m3_miso", r0, 32'hDEADBEEF);

        // back-to-back 16-bit words, second TX word supplied mid-word
        push_tx(32'h1111);
        rx0 = rx_cnt;
        un0 = un_cnt;
        rxq.push_back(32'hCAFE);
        rxq.push_back(32'h0F0F);
        frame(0, 1, 16, 2, 32'hCAFE, 32'h0F0F, 1, 32'h2222, 0, r0, r1);
        chk("b2b_miso0", r0, 32'h1111);
        chk("b2b_miso1", r1, 32'h2222);
        chk("b2b_rxpulses", rx_cnt - rx0, 2);
        chk("b2b_txunder", un_cnt - un0, 0);

        // underrun on the second word
        push_tx(32'h1111);
        un0 = un_cnt;
        rxq.push_back(32'h8001);
        rxq.push_back(32'h7FFE);
        frame(0, 1, 16, 2, 32'h8001, 32'h7FFE, 0, 0, 0, r0, r1);
        chk("un_miso0", r0, 32'h1111);
        chk("un_miso1", r1, 32'h0000);
        chk("un_txunder", un_cnt - un0, 1);

        // abort after 5 of 8 bits, then a clean frame
        push_tx(32'h96);
        rx0 = rx_cnt;
`ifdef SC_SPI_TGT_PARTIAL_EN
        rxq.push_back(32'h07);
        frame(0, 0, 8, 1, 32'h3C, 0, 0, 0, 5, r0, r1);
        chk("abort_rxpulses", rx_cnt - rx0, 1);
`else
        frame(0, 0, 8, 1, 32'h3C, 0, 0, 0, 5, r0, r1);
        chk("abort_rxpulses", rx_cnt - rx0, 0);
`endif
        push_tx(32'h5A);
        rxq.push_back(32'hE7);
        frame(0, 0, 8, 1, 32'hE7, 0, 0, 0, 0, r0, r1);
        chk("post_abort_miso", r0, 32'h5A);

        // reset mid-frame
        push_tx(32'h77);
        CPOL = 1'b0;
        CPHA = 1'b0;
        DWIDTH = 5'd7;
        SSCLK = 1'b0;
        cyc(4);
        SCSB = 1'b0;
        SMOSI = 1'b1;
        cyc(H); SSCLK = 1'b1;
        cyc(H); SSCLK = 1'b0;
        cyc(H); SSCLK = 1'b1;
        cyc(3);
        chk("mid_busy", BUSY, 1);
        #2 SYSRST = 1'b1;
        #1;
        chk("mr_rxdata", RXDATA, 0);
        chk("mr_rxvalid", RXVALID, 0);
        chk("mr_txready", TXREADY, 1);
        chk("mr_txunder", TXUNDER, 0);
        chk("mr_busy", BUSY, 0);
        chk("mr_smiso", SMISO, 0);
        chk("mr_smisooe", SMISOOE, 0);
        @(negedge SPICLK);
        SSCLK = 1'b0;
        SCSB = 1'b1;
        SYSRST = 1'b0;
        cyc(10);
        push_tx(32'h5A);
        rxq.push_back(32'hC3);
        frame(0, 0, 8, 1, 32'hC3, 0, 0, 0, 0, r0, r1);
        chk("post_rst_miso", r0, 32'h5A);

        cyc(10);
        chk("rxq_drained", rxq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
